// File: rtl/ex_seq_control.sv
// EX-stage sequencing control: result select, branch enables and issue/stall
// handling for multi-cycle HI/LO accumulator operations and the blocking MUL.
//
// state  | meaning
// IDLE   | nothing in flight, EX executes normally
// BUSY   | accumulator op in flight; HI/LO readers and writers stall
// MULW   | blocking MUL in flight; EX held until the result is ready
module ex_seq_control #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       ALUOp,
   input  logic       MULOp,
   input  logic       Jump,
   input  logic       Branch,
   input  logic       RegWriteIn,
   input  logic       BRAtaken,
   input  logic       ALUEn,
   input  logic       Flush,
   input  logic [5:0] Func,
   output logic       ACCEn,
   output logic       MULSelB,
   output logic       RegWriteOut,
   output logic       BRAEn,
   output logic       BranchTaken,
   output logic [1:0] OutSel,
   output logic       Stall,
   output logic       MulStart,
   output logic       DivStart,
   output logic       AccBusy
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_MULW} state_t;

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;

   logic alu_mf, alu_mt, acc_mul, acc_div, op_mul, alu_listed, blocking;

   assign alu_mf     = ALUOp && (Func == 6'h10 || Func == 6'h12);
   assign alu_mt     = ALUOp && (Func == 6'h11 || Func == 6'h13);
   assign acc_div    = ALUOp && (Func == 6'h1A || Func == 6'h1B);
   assign acc_mul    = (ALUOp && (Func == 6'h18 || Func == 6'h19)) ||
                       (MULOp && (Func == 6'h00 || Func == 6'h01 ||
                                  Func == 6'h04 || Func == 6'h05));
   assign op_mul     = MULOp && (Func == 6'h02);
   assign alu_listed = alu_mf || alu_mt || acc_div ||
                       (ALUOp && (Func == 6'h18 || Func == 6'h19));
   assign blocking   = alu_mf || alu_mt || acc_mul || acc_div || op_mul;

   assign AccBusy = (state_q == S_BUSY);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ACCEn       = 1'b0;
      MULSelB     = 1'b1;
      RegWriteOut = RegWriteIn;
      BRAEn       = 1'b0;
      BranchTaken = 1'b0;
      OutSel      = 2'b00;
      Stall       = 1'b0;
      MulStart    = 1'b0;
      DivStart    = 1'b0;

      case (state_q)
         S_MULW: begin
            // The held MUL is the only instruction in EX; decode flags are ignored.
            cnt_d = cnt_q - 6'd1;
            if (cnt_q <= 6'd1) begin
               OutSel  = 2'b10;
               state_d = S_IDLE;
            end else begin
               Stall       = 1'b1;
               RegWriteOut = 1'b0;
            end
            if (Flush) begin
               state_d = S_IDLE;
               cnt_d   = 6'd0;
            end
         end
         S_IDLE, S_BUSY: begin
            if (state_q == S_BUSY) begin
               cnt_d = cnt_q - 6'd1;
               if (cnt_q <= 6'd1) state_d = S_IDLE;
            end
            if (Jump || Branch) begin
               BRAEn       = 1'b1;
               OutSel      = 2'b01;
               BranchTaken = BRAtaken;
               RegWriteOut = RegWriteIn && BRAtaken;
            end else if (ALUOp && !alu_listed) begin
               RegWriteOut = ALUEn;
            end else if (blocking && state_q == S_BUSY) begin
               Stall       = 1'b1;
               RegWriteOut = 1'b0;
            end else if (acc_mul || acc_div) begin
               ACCEn    = 1'b1;
               OutSel   = 2'b10;
               MulStart = acc_mul;
               DivStart = acc_div;
               if (!Flush) begin
                  cnt_d   = acc_div ? 6'(DIV_LAT) : 6'(MUL_LAT);
                  state_d = S_BUSY;
               end
            end else if (alu_mf || alu_mt) begin
               ACCEn   = 1'b1;
               OutSel  = 2'b10;
               MULSelB = !alu_mt;
            end else if (op_mul) begin
               Stall       = 1'b1;
               MulStart    = 1'b1;
               RegWriteOut = 1'b0;
               if (!Flush) begin
                  cnt_d   = 6'(MUL_LAT);
                  state_d = S_MULW;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
         end
      endcase

      if (Flush) begin
         ACCEn       = 1'b0;
         RegWriteOut = 1'b0;
         BRAEn       = 1'b0;
         BranchTaken = 1'b0;
         Stall       = 1'b0;
         MulStart    = 1'b0;
         DivStart    = 1'b0;
      end

      // Outputs fall to their idle values for as long as Reset is held.
      if (Reset) begin
         ACCEn       = 1'b0;
         MULSelB     = 1'b1;
         RegWriteOut = 1'b0;
         BRAEn       = 1'b0;
         BranchTaken = 1'b0;
         OutSel      = 2'b00;
         Stall       = 1'b0;
         MulStart    = 1'b0;
         DivStart    = 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_seq_control.sv
// Bench for ex_seq_control: fixed vectors, directed multi-cycle sequences and
// random traffic against a timestamp-based reference model (two latency configs).
module tb_ex_seq_control;

   typedef struct packed {
      logic       alu;
      logic       mulop;
      logic       jmp;
      logic       br;
      logic       rwi;
      logic       bra;
      logic       aluen;
      logic       flush;
      logic [5:0] func;
   } in_t;

   typedef struct packed {
      logic       acc;
      logic       selb;
      logic       rwo;
      logic       braen;
      logic       bt;
      logic [1:0] outsel;
      logic       stall;
      logic       ms;
      logic       ds;
      logic       busy;
   } out_t;

   typedef struct {
      string name;
      in_t   vin;
      out_t  vexp;
   } vec_t;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       ALUOp = 1'b0, MULOp = 1'b0, Jump = 1'b0, Branch = 1'b0;
   logic       RegWriteIn = 1'b0, BRAtaken = 1'b0, ALUEn = 1'b0, Flush = 1'b0;
   logic [5:0] Func = 6'd0;

   logic       a0, s0, r0, be0, bt0, st0, ms0, ds0, bz0;
   logic [1:0] os0;
   logic       a1, s1, r1, be1, bt1, st1, ms1, ds1, bz1;
   logic [1:0] os1;
   out_t       o0, o1;

   assign o0 = {a0, s0, r0, be0, bt0, os0, st0, ms0, ds0, bz0};
   assign o1 = {a1, s1, r1, be1, bt1, os1, st1, ms1, ds1, bz1};

   ex_seq_control #(.MUL_LAT(4), .DIV_LAT(32)) u0 (
      .Clock(Clock), .Reset(Reset), .ALUOp(ALUOp), .MULOp(MULOp), .Jump(Jump),
      .Branch(Branch), .RegWriteIn(RegWriteIn), .BRAtaken(BRAtaken), .ALUEn(ALUEn),
      .Flush(Flush), .Func(Func), .ACCEn(a0), .MULSelB(s0), .RegWriteOut(r0),
      .BRAEn(be0), .BranchTaken(bt0), .OutSel(os0), .Stall(st0), .MulStart(ms0),
      .DivStart(ds0), .AccBusy(bz0));

   ex_seq_control #(.MUL_LAT(1), .DIV_LAT(1)) u1 (
      .Clock(Clock), .Reset(Reset), .ALUOp(ALUOp), .MULOp(MULOp), .Jump(Jump),
      .Branch(Branch), .RegWriteIn(RegWriteIn), .BRAtaken(BRAtaken), .ALUEn(ALUEn),
      .Flush(Flush), .Func(Func), .ACCEn(a1), .MULSelB(s1), .RegWriteOut(r1),
      .BRAEn(be1), .BranchTaken(bt1), .OutSel(os1), .Stall(st1), .MulStart(ms1),
      .DivStart(ds1), .AccBusy(bz1));

   always #5 Clock = ~Clock;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int acc_iss[2], acc_end[2], mul_iss[2], mul_end[2];

   function automatic int lat_mul(int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic int lat_div(int k);
      return (k == 0) ? 32 : 1;
   endfunction

   function automatic in_t mk(logic alu, logic mulop, logic jmp, logic br, logic [5:0] f,
                              logic rwi, logic bra, logic aluen, logic flush);
      in_t v;
      v.alu = alu; v.mulop = mulop; v.jmp = jmp; v.br = br; v.func = f;
      v.rwi = rwi; v.bra = bra; v.aluen = aluen; v.flush = flush;
      return v;
   endfunction

   function automatic out_t mo(logic acc, logic selb, logic rwo, logic braen, logic bt,
                               logic [1:0] os, logic stall, logic ms, logic ds, logic busy);
      return {acc, selb, rwo, braen, bt, os, stall, ms, ds, busy};
   endfunction

   task automatic chk(string n, int got, int expv);
      total_cnt++;
      if (got == expv) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", n, got, expv);
   endtask

   task automatic chk_out(string n, out_t got, out_t expv);
      total_cnt++;
      if (got == expv) pass_cnt++;
      else $display("FAIL %s: got %b expected %b (acc selb rwo braen bt os[2] stall ms ds busy)",
                    n, got, expv);
   endtask

   // Reference: an op issued at cycle t occupies cycles t+1 .. t+LAT.
   task automatic model(int k, in_t v, logic rst, output out_t e);
      logic busy, in_mul;
      logic mf, mt, mult, div, madd, mul;
      e = mo(1'b0, 1'b1, v.rwi, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (rst) begin
         acc_iss[k] = -1000; acc_end[k] = -1000;
         mul_iss[k] = -1000; mul_end[k] = -1000;
      end
      busy   = (cyc > acc_iss[k]) && (cyc <= acc_end[k]);
      in_mul = (cyc > mul_iss[k]) && (cyc <= mul_end[k]);
      e.busy = busy;
      mf   = v.alu && (v.func inside {6'h10, 6'h12});
      mt   = v.alu && (v.func inside {6'h11, 6'h13});
      mult = v.alu && (v.func inside {6'h18, 6'h19});
      div  = v.alu && (v.func inside {6'h1A, 6'h1B});
      madd = v.mulop && (v.func inside {6'h00, 6'h01, 6'h04, 6'h05});
      mul  = v.mulop && (v.func == 6'h02);
      if (rst) begin
         e.rwo = 1'b0;
      end else if (in_mul) begin
         if (cyc == mul_end[k]) e.outsel = 2'b10;
         else begin e.stall = 1'b1; e.rwo = 1'b0; end
         if (v.flush) mul_end[k] = -1000;
      end else begin
         if (v.jmp || v.br) begin
            e.braen = 1'b1; e.outsel = 2'b01; e.bt = v.bra; e.rwo = v.rwi & v.bra;
         end else if (v.alu && !(mf || mt || mult || div)) begin
            e.rwo = v.aluen;
         end else if (busy && (mf || mt || mult || div || madd || mul)) begin
            e.stall = 1'b1; e.rwo = 1'b0;
         end else if (mult || div || madd) begin
            e.acc = 1'b1; e.outsel = 2'b10; e.ms = !div; e.ds = div;
            if (!v.flush) begin
               acc_iss[k] = cyc;
               acc_end[k] = cyc + (div ? lat_div(k) : lat_mul(k));
            end
         end else if (mf || mt) begin
            e.acc = 1'b1; e.outsel = 2'b10; e.selb = !mt;
         end else if (mul) begin
            e.stall = 1'b1; e.ms = 1'b1; e.rwo = 1'b0;
            if (!v.flush) begin
               mul_iss[k] = cyc;
               mul_end[k] = cyc + lat_mul(k);
            end
         end
      end
      if (v.flush && !rst) begin
         e.acc = 1'b0; e.rwo = 1'b0; e.braen = 1'b0; e.bt = 1'b0;
         e.stall = 1'b0; e.ms = 1'b0; e.ds = 1'b0;
      end
   endtask

   task automatic step(in_t v, logic rst);
      out_t e0, e1;
      @(negedge Clock);
      Reset = rst; ALUOp = v.alu; MULOp = v.mulop; Jump = v.jmp; Branch = v.br;
      RegWriteIn = v.rwi; BRAtaken = v.bra; ALUEn = v.aluen; Flush = v.flush; Func = v.func;
      #2;
      model(0, v, rst, e0);
      model(1, v, rst, e1);
      chk_out($sformatf("model_u0 cyc%0d", cyc), o0, e0);
      chk_out($sformatf("model_u1 cyc%0d", cyc), o1, e1);
      cyc++;
   endtask

   function automatic in_t rnd_ins();
      in_t v;
      int  c, m;
      v = '0;
      v.rwi = 1'($urandom); v.bra = 1'($urandom); v.aluen = 1'($urandom);
      c = $urandom_range(0, 7);
      m = $urandom_range(0, 6);
      case (c)
         1: begin v.alu = 1'b1; v.func = 6'($urandom_range(0, 63)); end
         2: begin v.alu = 1'b1; v.func = 6'h10 + 6'($urandom_range(0, 3)); end
         3: begin v.alu = 1'b1; v.func = 6'h18 + 6'($urandom_range(0, 3)); end
         4: begin
            v.mulop = 1'b1;
            case (m)
               0: v.func = 6'h00;
               1: v.func = 6'h01;
               2: v.func = 6'h02;
               3: v.func = 6'h04;
               4: v.func = 6'h05;
               5: v.func = 6'h20;
               default: v.func = 6'h21;
            endcase
         end
         5: begin v.mulop = 1'b1; v.func = 6'($urandom_range(0, 63)); end
         6: v.jmp = 1'b1;
         7: v.br = 1'b1;
         default: ;
      endcase
      return v;
   endfunction

   in_t bub, v;
   vec_t vq[$];
   int stalls, starts, busy_n, rwo_n, done;

   initial begin
      for (int k = 0; k < 2; k++) begin
         acc_iss[k] = -1000; acc_end[k] = -1000; mul_iss[k] = -1000; mul_end[k] = -1000;
      end
      bub = '0;
      step(bub, 1'b1);
      chk_out("reset_u0", o0, mo(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0));

      vq.push_back('{"bubble",      mk(0,0,0,0,6'h00,1,0,0,0), mo(0,1,1,0,0,2'd0,0,0,0,0)});
      vq.push_back('{"alu_en",      mk(1,0,0,0,6'h20,0,0,1,0), mo(0,1,1,0,0,2'd0,0,0,0,0)});
      vq.push_back('{"alu_noen",    mk(1,0,0,0,6'h20,1,0,0,0), mo(0,1,0,0,0,2'd0,0,0,0,0)});
      vq.push_back('{"mfhi",        mk(1,0,0,0,6'h10,1,0,0,0), mo(1,1,1,0,0,2'd2,0,0,0,0)});
      vq.push_back('{"mtlo",        mk(1,0,0,0,6'h13,0,0,0,0), mo(1,0,0,0,0,2'd2,0,0,0,0)});
      vq.push_back('{"mult",        mk(1,0,0,0,6'h18,0,0,0,0), mo(1,1,0,0,0,2'd2,0,1,0,0)});
      vq.push_back('{"divu",        mk(1,0,0,0,6'h1B,0,0,0,0), mo(1,1,0,0,0,2'd2,0,0,1,0)});
      vq.push_back('{"madd",        mk(0,1,0,0,6'h00,0,0,0,0), mo(1,1,0,0,0,2'd2,0,1,0,0)});
      vq.push_back('{"msubu",       mk(0,1,0,0,6'h05,0,0,0,0), mo(1,1,0,0,0,2'd2,0,1,0,0)});
      vq.push_back('{"clz",         mk(0,1,0,0,6'h20,1,0,0,0), mo(0,1,1,0,0,2'd0,0,0,0,0)});
      vq.push_back('{"mul_issue",   mk(0,1,0,0,6'h02,1,0,0,0), mo(0,1,0,0,0,2'd0,1,1,0,0)});
      vq.push_back('{"br_taken",    mk(0,0,0,1,6'h00,1,1,0,0), mo(0,1,1,1,1,2'd1,0,0,0,0)});
      vq.push_back('{"br_nottaken", mk(0,0,0,1,6'h00,1,0,0,0), mo(0,1,0,1,0,2'd1,0,0,0,0)});
      vq.push_back('{"jump_norwi",  mk(0,0,1,0,6'h00,0,1,0,0), mo(0,1,0,1,1,2'd1,0,0,0,0)});
      vq.push_back('{"mult_flush",  mk(1,0,0,0,6'h18,1,0,0,1), mo(0,1,0,0,0,2'd2,0,0,0,0)});
      vq.push_back('{"br_flush",    mk(0,0,0,1,6'h00,1,1,0,1), mo(0,1,0,0,0,2'd1,0,0,0,0)});
      vq.push_back('{"mul_flush",   mk(0,1,0,0,6'h02,1,0,0,1), mo(0,1,0,0,0,2'd0,0,0,0,0)});
      vq.push_back('{"alu_flush",   mk(1,0,0,0,6'h21,1,0,1,1), mo(0,1,0,0,0,2'd0,0,0,0,0)});
      foreach (vq[i]) begin
         step(vq[i].vin, 1'b0);
         chk_out(vq[i].name, o0, vq[i].vexp);
         step(bub, 1'b1);
      end

      // MULT then MFLO held behind it
      step(mk(1,0,0,0,6'h18,0,0,0,0), 1'b0);
      chk("mult_start", int'(o0.ms), 1);
      stalls = 0; starts = 0; done = 0;
      for (int c = 0; c < 10 && done == 0; c++) begin
         step(mk(1,0,0,0,6'h12,1,0,0,0), 1'b0);
         starts += int'(o0.ms);
         if (o0.stall) stalls++;
         else begin
            done = 1;
            chk("mflo_acc", int'(o0.acc), 1);
            chk("mflo_outsel", int'(o0.outsel), 2);
         end
      end
      chk("mflo_done", done, 1);
      chk("mflo_stalls", stalls, 4);
      chk("mflo_no_restart", starts, 0);

      // DIV then 32 independent ALU ops
      step(bub, 1'b1);
      step(mk(1,0,0,0,6'h1A,0,0,0,0), 1'b0);
      chk("div_start", int'(o0.ds), 1);
      stalls = 0; busy_n = 0; rwo_n = 0;
      for (int c = 0; c < 32; c++) begin
         step(mk(1,0,0,0,6'h20,0,0,1,0), 1'b0);
         stalls += int'(o0.stall); busy_n += int'(o0.busy); rwo_n += int'(o0.rwo);
      end
      chk("div_alu_stalls", stalls, 0);
      chk("div_busy_cycles", busy_n, 32);
      chk("div_alu_writes", rwo_n, 32);
      step(bub, 1'b0);
      chk("div_busy_end", int'(o0.busy), 0);

      // Blocking MUL
      step(bub, 1'b1);
      step(mk(0,1,0,0,6'h02,1,0,0,0), 1'b0);
      chk("mul_start", int'(o0.ms), 1);
      stalls = int'(o0.stall); done = 0;
      for (int c = 0; c < 10 && done == 0; c++) begin
         step(mk(0,1,0,0,6'h02,1,0,0,0), 1'b0);
         if (o0.stall) stalls++;
         else begin
            done = 1;
            chk("mul_wb_outsel", int'(o0.outsel), 2);
            chk("mul_wb_rwo", int'(o0.rwo), 1);
            chk("mul_wb_nostart", int'(o0.ms), 0);
         end
      end
      chk("mul_done", done, 1);
      chk("mul_stalls", stalls, 4);

      // Flush in the second MULW cycle
      step(bub, 1'b1);
      rwo_n = 0;
      step(mk(0,1,0,0,6'h02,1,0,0,0), 1'b0); rwo_n += int'(o0.rwo);
      step(mk(0,1,0,0,6'h02,1,0,0,0), 1'b0); rwo_n += int'(o0.rwo);
      step(mk(0,1,0,0,6'h02,1,0,0,1), 1'b0); rwo_n += int'(o0.rwo);
      chk("mulw_flush_stall", int'(o0.stall), 0);
      step(mk(1,0,0,0,6'h10,1,0,0,0), 1'b0);
      chk("post_flush_stall", int'(o0.stall), 0);
      chk("post_flush_acc", int'(o0.acc), 1);
      chk("mulw_flush_nowrite", rwo_n, 0);

      // Reset in the third BUSY cycle of DIV
      step(bub, 1'b1);
      step(mk(1,0,0,0,6'h1A,0,0,0,0), 1'b0);
      step(bub, 1'b0);
      step(bub, 1'b0);
      chk("busy_before_rst", int'(o0.busy), 1);
      step(bub, 1'b1);
      chk("busy_at_rst", int'(o0.busy), 0);
      step(mk(1,0,0,0,6'h10,1,0,0,0), 1'b0);
      chk("mfhi_after_rst_stall", int'(o0.stall), 0);
      chk("mfhi_after_rst_acc", int'(o0.acc), 1);
      chk("no_div_after_rst", int'(o0.ds), 0);

      // Latency-1 instance
      step(bub, 1'b1);
      step(mk(0,1,0,0,6'h02,1,0,0,0), 1'b0);
      chk("l1_mul_issue_stall", int'(o1.stall), 1);
      step(mk(0,1,0,0,6'h02,1,0,0,0), 1'b0);
      chk("l1_mul_wb_stall", int'(o1.stall), 0);
      chk("l1_mul_wb_rwo", int'(o1.rwo), 1);
      chk("l1_mul_wb_outsel", int'(o1.outsel), 2);
      step(bub, 1'b1);
      step(mk(1,0,0,0,6'h18,0,0,0,0), 1'b0);
      step(bub, 1'b0);
      chk("l1_busy_one", int'(o1.busy), 1);
      step(bub, 1'b0);
      chk("l1_busy_over", int'(o1.busy), 0);

      // Random traffic; stalled instructions are usually held like a real pipeline
      step(bub, 1'b1);
      v = bub;
      for (int n = 0; n < 2000; n++) begin
         if (!(o0.stall && $urandom_range(0, 3) != 0)) v = rnd_ins();
         v.flush = ($urandom_range(0, 7) == 0);
         step(v, $urandom_range(0, 99) == 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
